// File: rtl/forex_result_port.sv
// Host-facing read port of the FOREX accelerator: buffers detected negative-cycle vertex
// streams in a FIFO and serves them, with status/control/total counters, over Avalon-MM.
module forex_result_port #(
  parameter int PRED_BITS = 6,
  parameter int DEPTH     = 16,
  parameter int CNT_BITS  = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 chipselect,
  input  logic                 read,
  input  logic                 write,
  input  logic [2:0]           address,
  input  logic [31:0]          writedata,
  output logic [31:0]          readdata,
  output logic                 irq,
  input  logic                 cyc_valid,
  input  logic [PRED_BITS-1:0] cyc_vertex,
  input  logic                 cyc_last,
  output logic                 cyc_ready
);

  localparam int PTR_BITS = $clog2(DEPTH);

  logic [PRED_BITS:0]    mem [DEPTH];
  logic [PTR_BITS-1:0]   wr_ptr, rd_ptr;
  logic [CNT_BITS-1:0]   count, count_nxt;
  logic [CNT_BITS-1:0]   pending, pending_nxt;
  logic                  irq_en, irq_en_nxt;
  logic [31:0]           total;
  logic [31:0]           rd_mux;
  logic [PRED_BITS:0]    head;
  logic                  full, empty;
  logic                  ctrl_wr, flush_now;
  logic                  rd_sel, push, pop, push_last, pop_last;
  logic                  unused_writedata;

  assign unused_writedata = ^writedata[31:2];

  assign full      = (count == CNT_BITS'(DEPTH));
  assign empty     = (count == '0);
  assign ctrl_wr   = chipselect && write && (address == 3'd2);
  assign flush_now = ctrl_wr && writedata[1];
  assign cyc_ready = !reset && !full && !flush_now;

  assign head      = mem[rd_ptr];
  assign rd_sel    = chipselect && read;
  assign push      = cyc_valid && cyc_ready;
  assign pop       = rd_sel && (address == 3'd0) && !empty;
  assign push_last = push && cyc_last;
  assign pop_last  = pop && head[PRED_BITS];

  // Next-state occupancy; a flush wins over any push or pop in the same cycle.
  always_comb begin
    count_nxt   = count;
    pending_nxt = pending;
    irq_en_nxt  = ctrl_wr ? writedata[0] : irq_en;
    if (flush_now) begin
      count_nxt   = '0;
      pending_nxt = '0;
    end else begin
      count_nxt = count + CNT_BITS'(push) - CNT_BITS'(pop);
      if (push_last && !pop_last)
        pending_nxt = pending + 1'b1;
      else if (!push_last && pop_last)
        pending_nxt = pending - 1'b1;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      3'd0: if (!empty)
              rd_mux = {1'b1, head[PRED_BITS], {(30-PRED_BITS){1'b0}}, head[PRED_BITS-1:0]};
      3'd1: rd_mux = {8'd0, {(8-CNT_BITS){1'b0}}, pending, {(8-CNT_BITS){1'b0}}, count,
                      5'd0, irq_en, full, empty};
      3'd2: rd_mux = {31'd0, irq_en};
      3'd3: rd_mux = total;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= {cyc_last, cyc_vertex};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      pending  <= '0;
      irq_en   <= 1'b0;
      total    <= '0;
      readdata <= '0;
      irq      <= 1'b0;
    end else begin
      count    <= count_nxt;
      pending  <= pending_nxt;
      irq_en   <= irq_en_nxt;
      irq      <= irq_en_nxt && (pending_nxt != '0);
      readdata <= rd_sel ? rd_mux : 32'd0;
      if (push_last)
        total <= total + 32'd1;
      if (flush_now) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule
